// File: rtl/control_sequencer_if.sv
// Instruction-ROM and datapath-control bundle between the sequencer (master) and
// the ROM/register-file/ALU/RAM datapath (slave).
interface control_sequencer_if #(
   parameter int unsigned PC_W = 8,
   parameter int unsigned IW   = 32
);
   logic            start;
   logic [IW-1:0]   instr;
   logic [3:0]      signalBits;
   logic [PC_W-1:0] pc;
   logic [4:0]      readA;
   logic [4:0]      readB;
   logic [4:0]      writeReg;
   logic [4:0]      functionsel;
   logic            ALUcarry;
   logic            write;
   logic            RAMwrite;
   logic            muxSelect;
   logic            busy;
   logic            halted;

   modport master (
      input  start, instr, signalBits,
      output pc, readA, readB, writeReg, functionsel, ALUcarry,
             write, RAMwrite, muxSelect, busy, halted
   );

   modport slave (
      output start, instr, signalBits,
      input  pc, readA, readB, writeReg, functionsel, ALUcarry,
             write, RAMwrite, muxSelect, busy, halted
   );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the register-file/ALU/RAM datapath.
// Owns the PC, the instruction register and the ALU flag register used by branches.
module control_sequencer #(
   parameter int unsigned PC_W = 8,
   parameter int unsigned IW   = 32
) (
   input logic                 clk,
   input logic                 rst,
   control_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEM       = 3'd4,
      S_WRITEBACK = 3'd5,
      S_HALT      = 3'd6
   } state_e;

   localparam logic [3:0] OP_ALU   = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_STORE = 4'h3;
   localparam logic [3:0] OP_BRZ   = 4'h4;
   localparam logic [3:0] OP_BRN   = 4'h5;
   localparam logic [3:0] OP_BRC   = 4'h6;
   localparam logic [3:0] OP_JMP   = 4'h7;
   localparam logic [3:0] OP_HALT  = 4'hF;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [IW-1:0]   ir_q, ir_d;
   logic [3:0]      flags_q, flags_d;
   logic            write_q, write_d;
   logic            ram_write_q, ram_write_d;
   logic            mux_select_q, mux_select_d;
   logic            busy_q, busy_d;
   logic            halted_q, halted_d;

   logic [3:0]      dec_op;
   logic [3:0]      ir_op;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] target;
   logic            unused_flag_v;

   assign dec_op        = bus.instr[31:28];
   assign ir_op         = ir_q[31:28];
   assign pc_inc        = pc_q + PC_W'(1);
   assign target        = PC_W'(ir_q[7:0]);
   assign unused_flag_v = flags_q[3];

   // Next state, PC, IR and flags; control strobes are derived from the next state
   // so every datapath control leaves a flop.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      flags_d      = flags_q;
      write_d      = 1'b0;
      ram_write_d  = 1'b0;
      mux_select_d = 1'b0;
      busy_d       = 1'b0;
      halted_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_FETCH;
               pc_d    = '0;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            ir_d = bus.instr;
            if (dec_op == OP_HALT) begin
               state_d = S_HALT;
            end else if (dec_op inside {OP_ALU, OP_LOAD, OP_STORE, OP_BRZ,
                                        OP_BRN, OP_BRC, OP_JMP}) begin
               state_d = S_EXECUTE;
            end else begin
               state_d = S_FETCH;
               pc_d    = pc_inc;
            end
         end
         S_EXECUTE: begin
            state_d = S_FETCH;
            case (ir_op)
               OP_ALU: begin
                  flags_d = bus.signalBits;
                  state_d = S_WRITEBACK;
               end
               OP_LOAD, OP_STORE: state_d = S_MEM;
               OP_BRZ:  pc_d = flags_q[0] ? target : pc_inc;
               OP_BRN:  pc_d = flags_q[1] ? target : pc_inc;
               OP_BRC:  pc_d = flags_q[2] ? target : pc_inc;
               OP_JMP:  pc_d = target;
               default: pc_d = pc_inc;
            endcase
         end
         S_MEM: begin
            if (ir_op == OP_LOAD) begin
               state_d = S_WRITEBACK;
            end else begin
               state_d = S_FETCH;
               pc_d    = pc_inc;
            end
         end
         S_WRITEBACK: begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase

      write_d      = (state_d == S_WRITEBACK);
      mux_select_d = write_d && (ir_d[31:28] == OP_LOAD);
      ram_write_d  = (state_d == S_MEM) && (ir_d[31:28] == OP_STORE);
      busy_d       = !(state_d inside {S_IDLE, S_HALT});
      halted_d     = (state_d == S_HALT);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         ir_q         <= '0;
         flags_q      <= '0;
         write_q      <= 1'b0;
         ram_write_q  <= 1'b0;
         mux_select_q <= 1'b0;
         busy_q       <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         flags_q      <= flags_d;
         write_q      <= write_d;
         ram_write_q  <= ram_write_d;
         mux_select_q <= mux_select_d;
         busy_q       <= busy_d;
         halted_q     <= halted_d;
      end
   end

   // Register selects come straight from the IR and hold until the next decode.
   assign bus.pc          = pc_q;
   assign bus.writeReg    = ir_q[27:23];
   assign bus.readA       = ir_q[22:18];
   assign bus.readB       = ir_q[17:13];
   assign bus.functionsel = ir_q[12:8];
   assign bus.ALUcarry    = ir_q[7];
   assign bus.write       = write_q;
   assign bus.RAMwrite    = ram_write_q;
   assign bus.muxSelect   = mux_select_q;
   assign bus.busy        = busy_q;
   assign bus.halted      = halted_q;

endmodule
